// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and sizing for the integer register file and its
// pending-writer scoreboard.
//   XLEN  - register data width
//   NREGS - architectural registers (x0..x31)
//   AW    - register address width, clog2(NREGS)
//   CNTW  - pending-writer counter width per register
package regfile_scoreboard_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int CNTW  = 2;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [CNTW-1:0] pend_cnt_t;

  // All-ones counter value: the most writers that may be in flight to one register.
  localparam pend_cnt_t CNT_MAX = '1;

  // How a writing instruction leaves the pipeline.
  typedef enum logic [1:0] {
    WB_NONE   = 2'd0,
    WB_RETIRE = 2'd1,
    WB_SQUASH = 2'd2
  } wb_kind_t;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One pending-writer counter of the scoreboard.
//   clk, rst_n - clock, async active-low reset
//   inc_i      - a writer to this register was issued
//   dec_i      - a writer to this register left the pipeline
//   cnt_o      - writers currently in flight
//   undf_o     - release seen with no writer in flight (event, combinational)
module sb_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            undf_o
);

  pend_cnt_t cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc_i && !dec_i) begin
      // Issue stalls at CNT_MAX, so the hold here is only a safety net.
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign cnt_o  = cnt;
  assign undf_o = dec_i && !inc_i && (cnt == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass and a per-register
// pending-writer scoreboard driving the ID stall.
//   clk, rst_n          - clock, async active-low reset
//   reg_write_i/rd_*    - writeback port
//   rs1/rs2_addr_i      - ID read addresses; rs1/rs2_data_o bypassed read data
//   rs1/rs2_used_i      - ID instruction actually reads that source
//   issue_*             - ID instruction requesting to advance, and its rd
//   rel_valid_i/rel_rd_i- a writer leaves the pipeline (retired or squashed)
//   stall_o             - hold ID this cycle
//   err_o               - sticky scoreboard underflow
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_write_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            issue_valid_i,
  input  logic            issue_wr_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            rel_valid_i,
  input  logic [AW-1:0]   rel_rd_i,
  output logic            stall_o,
  output logic            err_o
);

  logic [XLEN-1:0] regs [NREGS];
  pend_cnt_t       cnt  [NREGS];
  logic [NREGS-1:1] undf;
  logic             issue_acc;

  // Register array; regs[0] is never written and reads of x0 are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_write_i && (rd_addr_i != '0)) begin
      regs[rd_addr_i] <= rd_data_i;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input reg_addr_t a);
    if (a == '0)                           return '0;
    else if (reg_write_i && rd_addr_i == a) return rd_data_i;
    else                                   return regs[a];
  endfunction

  // A register whose only pending writer leaves this cycle is already safe to
  // read: its value comes through the bypass or is already in the array.
  function automatic logic busy(input reg_addr_t r);
    if (r == '0 || cnt[r] == '0) return 1'b0;
    return !((cnt[r] == pend_cnt_t'(1)) && rel_valid_i && (rel_rd_i == r));
  endfunction

  always_comb begin
    rs1_data_o = read_port(rs1_addr_i);
    rs2_data_o = read_port(rs2_addr_i);
    stall_o    = issue_valid_i &&
                 ((rs1_used_i && busy(rs1_addr_i)) ||
                  (rs2_used_i && busy(rs2_addr_i)) ||
                  (issue_wr_i && (issue_rd_i != '0) && (cnt[issue_rd_i] == CNT_MAX)));
  end

  assign issue_acc = issue_valid_i && !stall_o && issue_wr_i && (issue_rd_i != '0);

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (issue_acc && (issue_rd_i == reg_addr_t'(r))),
      .dec_i  (rel_valid_i && (rel_rd_i == reg_addr_t'(r))),
      .cnt_o  (cnt[r]),
      .undf_o (undf[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     err_o <= 1'b0;
    else if (|undf) err_o <= 1'b1;
  end

endmodule
